// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer.
// Holds the FSM state encoding, the x0 register index and the wait-counter width.
// No logic, only types and constants.
package pipeline_stall_ctrl_pkg;

  // Sequencer states; encoding 2'd3 is unused and recovers to ST_RUN.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_EX_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } ctrl_state_e;

  // Architectural zero register: writes to it never create a dependency.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Wide enough to count up to a 65535-cycle memory timeout.
  localparam int WCNT_W = 16;

endpackage

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of a load in EX.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by the stall sequencer.
module pipeline_stall_ctrl_load_use_detect
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // Compare both ID source operands against the load destination; x0 never hazards.
  always_comb begin
    rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    load_use_o = ex_memread_i && (ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central hazard/stall sequencer for the 5-stage RV32 pipeline registers.
// Latency: controls are combinational from state + inputs; FSM state updates one cycle later.
// Backpressure: a pending data-memory access freezes every stage until ready or timeout.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             ID_EX_memread,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_busy,
  input  logic             EX_redirect,
  input  logic             EX_MEM_memread,
  input  logic             EX_MEM_memwrite,
  input  logic             dmem_ready,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_en,
  output logic             ID_EX_flush,
  output logic             EX_stall,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles
);

  // Last wait-counter value before an unanswered access is forced to complete.
  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              mem_err_q;
  logic [CNT_W-1:0]  stall_q;

  logic mem_acc;
  logic load_use;
  logic timeout_hit;
  logic mem_freeze;

  pipeline_stall_ctrl_load_use_detect u_load_use_detect (
    .id_rs1_i      (ID_rs1),
    .id_rs2_i      (ID_rs2),
    .id_uses_rs1_i (ID_uses_rs1),
    .id_uses_rs2_i (ID_uses_rs2),
    .ex_memread_i  (ID_EX_memread),
    .ex_rd_i       (ID_EX_rd),
    .load_use_o    (load_use)
  );

  // Memory hazard terms: a timed-out access counts as complete so the pipe can move on.
  always_comb begin
    mem_acc     = EX_MEM_memread || EX_MEM_memwrite;
    timeout_hit = (state_q == ST_MEM_WAIT) && (wcnt_q == WCNT_LIMIT) && !dmem_ready;
    mem_freeze  = mem_acc && !dmem_ready && !timeout_hit;
  end

  // Priority-ordered stage controls: reset, memory freeze, EX busy, redirect, load-use, run.
  always_comb begin
    PC_en       = 1'b1;
    IF_ID_en    = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_en    = 1'b1;
    ID_EX_flush = 1'b0;
    EX_stall    = 1'b0;
    EX_MEM_en   = 1'b1;
    MEM_WB_en   = 1'b1;
    dmem_req    = mem_acc && !reset;
    if (reset) begin
      // Fill every stage with NOPs while reset is held.
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      EX_stall    = 1'b1;
    end else if (mem_freeze) begin
      PC_en     = 1'b0;
      IF_ID_en  = 1'b0;
      ID_EX_en  = 1'b0;
      EX_MEM_en = 1'b0;
      MEM_WB_en = 1'b0;
    end else if (EX_busy) begin
      // Front end holds; a bubble drains from EX into MEM.
      PC_en    = 1'b0;
      IF_ID_en = 1'b0;
      ID_EX_en = 1'b0;
      EX_stall = 1'b1;
    end else if (EX_redirect) begin
      // Wrong-path instructions in IF/ID and ID/EX are discarded; load-use is moot.
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      PC_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  // Sequencer state, memory wait counter, sticky timeout flag and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN, ST_EX_WAIT: begin
          if (mem_freeze) begin
            state_q <= ST_MEM_WAIT;
            wcnt_q  <= '0;
          end else begin
            state_q <= EX_busy ? ST_EX_WAIT : ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          wcnt_q <= wcnt_q + WCNT_W'(1);
          if (!mem_freeze) begin
            state_q <= EX_busy ? ST_EX_WAIT : ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase

      if (timeout_hit) begin
        mem_err_q <= 1'b1;
      end

      if (!PC_en && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign mem_err      = mem_err_q;
  assign ctrl_state   = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed hazard scenarios then random traffic.
// Every cycle all outputs are compared against a behavioural model of the hazard rules.
// Runs a fixed number of cycles and always ends with a summary line.
module tb_pipeline_stall_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 6;
  localparam longint SAT = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [4:0]    ID_rs1, ID_rs2, ID_EX_rd;
  logic          ID_uses_rs1, ID_uses_rs2, ID_EX_memread;
  logic          EX_busy, EX_redirect, EX_MEM_memread, EX_MEM_memwrite, dmem_ready;
  logic          PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush;
  logic          EX_stall, EX_MEM_en, MEM_WB_en, dmem_req, mem_err;
  logic [1:0]    ctrl_state;
  logic [CW-1:0] stall_cycles;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .ID_rs1          (ID_rs1),
    .ID_rs2          (ID_rs2),
    .ID_uses_rs1     (ID_uses_rs1),
    .ID_uses_rs2     (ID_uses_rs2),
    .ID_EX_memread   (ID_EX_memread),
    .ID_EX_rd        (ID_EX_rd),
    .EX_busy         (EX_busy),
    .EX_redirect     (EX_redirect),
    .EX_MEM_memread  (EX_MEM_memread),
    .EX_MEM_memwrite (EX_MEM_memwrite),
    .dmem_ready      (dmem_ready),
    .PC_en           (PC_en),
    .IF_ID_en        (IF_ID_en),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_en        (ID_EX_en),
    .ID_EX_flush     (ID_EX_flush),
    .EX_stall        (EX_stall),
    .EX_MEM_en       (EX_MEM_en),
    .MEM_WB_en       (MEM_WB_en),
    .dmem_req        (dmem_req),
    .mem_err         (mem_err),
    .ctrl_state      (ctrl_state),
    .stall_cycles    (stall_cycles)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: which wait the pipe is in and for how long.
  int     m_state;
  int     m_wait_age;
  bit     m_err;
  longint m_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected controls from the hazard rules.
  // Bit order: PC_en IF_ID_en IF_ID_flush ID_EX_en ID_EX_flush EX_stall EX_MEM_en MEM_WB_en dmem_req
  task automatic model_eval(output bit freeze, output bit tmo, output logic [8:0] e);
    bit acc, lu;
    acc    = EX_MEM_memread || EX_MEM_memwrite;
    lu     = ID_EX_memread && (ID_EX_rd != 0) &&
             ((ID_uses_rs1 && ID_rs1 == ID_EX_rd) || (ID_uses_rs2 && ID_rs2 == ID_EX_rd));
    tmo    = (m_state == 2) && (m_wait_age == TMO - 1) && !dmem_ready;
    freeze = acc && !dmem_ready && !tmo;
    if (reset)            e = 9'b1_1_1_1_1_1_1_1_0;
    else if (freeze)      e = {8'b0000_0000, acc};
    else if (EX_busy)     e = {8'b0_0_0_0_0_1_1_1, acc};
    else if (EX_redirect) e = {8'b1_1_1_1_1_0_1_1, acc};
    else if (lu)          e = {8'b0_0_0_1_1_0_1_1, acc};
    else                  e = {8'b1_1_0_1_0_0_1_1, acc};
  endtask

  // One cycle: inputs already driven; compare outputs, clock, advance the model.
  task automatic step();
    bit fr, tmo;
    logic [8:0] e;
    #2;
    model_eval(fr, tmo, e);
    chk("ctrl", {PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush,
                 EX_stall, EX_MEM_en, MEM_WB_en, dmem_req}, e);
    chk("ctrl_state", ctrl_state, m_state);
    chk("mem_err", mem_err, m_err);
    chk("stall_cycles", stall_cycles, m_stall);
    @(posedge clk);
    if (reset) begin
      m_state = 0; m_wait_age = 0; m_err = 0; m_stall = 0;
    end else begin
      if (m_state == 2)   m_wait_age++;
      else if (fr)        m_wait_age = 0;
      m_state = fr ? 2 : (EX_busy ? 1 : 0);
      if (tmo) m_err = 1;
      if (!e[8] && m_stall < SAT) m_stall++;
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; ID_rs1 = 0; ID_rs2 = 0; ID_EX_rd = 0;
    ID_uses_rs1 = 0; ID_uses_rs2 = 0; ID_EX_memread = 0;
    EX_busy = 0; EX_redirect = 0; EX_MEM_memread = 0; EX_MEM_memwrite = 0; dmem_ready = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ID_EX_memread = 1; ID_EX_rd = rd; ID_rs1 = rd; ID_uses_rs1 = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    m_state = 0; m_wait_age = 0; m_err = 0; m_stall = 0;
    @(posedge clk); #1;
    step(); step();

    // Load-use on x5: one bubble, one stall cycle counted.
    idle(); set_load_use(5'd5); step();
    idle(); step();
    chk("lu_stall_count", stall_cycles, 1);
    // Load into x0 never stalls.
    idle(); set_load_use(5'd0); step();
    idle(); step();
    chk("lu_x0_no_stall", stall_cycles, 1);

    // Memory wait answered after three cycles.
    idle(); EX_MEM_memread = 1;
    repeat (3) step();
    dmem_ready = 1; step();
    idle(); step();
    chk("memwait_no_err", mem_err, 0);

    // Memory never answers: forced completion and sticky error.
    idle(); EX_MEM_memwrite = 1;
    repeat (TMO + 1) step();
    idle(); repeat (3) step();
    chk("timeout_err_sticky", mem_err, 1);
    chk("timeout_back_to_run", ctrl_state, 0);

    // Multi-cycle EX with a pending redirect, consumed once EX frees up.
    idle(); EX_busy = 1; EX_redirect = 1;
    repeat (2) step();
    EX_busy = 0; step();
    idle(); step();

    // Redirect beats load-use in the same cycle.
    idle(); EX_redirect = 1; set_load_use(5'd7); step();
    idle(); step();

    // Reset during a memory wait, then the access restarts from a clean counter.
    idle(); EX_MEM_memread = 1;
    repeat (2) step();
    reset = 1; step();
    chk("rst_mid_wait_err", mem_err, 0);
    reset = 0; repeat (TMO + 2) step();
    idle(); step();

    // Random traffic with small register indices so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 199) == 0);
      ID_rs1          = 5'($urandom_range(0, 3));
      ID_rs2          = 5'($urandom_range(0, 3));
      ID_EX_rd        = 5'($urandom_range(0, 3));
      ID_uses_rs1     = 1'($urandom_range(0, 1));
      ID_uses_rs2     = 1'($urandom_range(0, 1));
      ID_EX_memread   = ($urandom_range(0, 2) == 0);
      EX_busy         = ($urandom_range(0, 3) == 0);
      EX_redirect     = ($urandom_range(0, 4) == 0);
      EX_MEM_memread  = ($urandom_range(0, 4) == 0);
      EX_MEM_memwrite = ($urandom_range(0, 6) == 0);
      dmem_ready      = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
